reduction_mux_sched: RTL
========================

// Module: reduction_mux_sched
// PURPOSE
//  Issue scheduler for reduction_mux in the unstructured-sparse datapath. Accepts a NUM_IN-bit nonzero
//  bitmask per operand group, then walks it and emits one (left,right) index pair per beat, lowest set
//  bits first. Drives the mux's {right,left} select bus plus per-lane valid and end-of-group flags for
//  the downstream accumulator. Processes 2 nonzeros/beat; a group takes max(1,ceil(popcount/2)) beats.
// PARAMETERS
//  NUM_IN   4  inputs of the mux = bitmask width (>=2)
//  SEL_IN   2  select width per lane; must equal $clog2(NUM_IN)
// PORTS
//  clk        in   1            clock, all state rises on posedge
//  rst        in   1            reset, asynchronous, active-high
//  mask       in   NUM_IN       nonzero bitmask of the group; bit i = input i holds a nonzero
//  mask_valid in   1            mask offered
//  mask_ready out  1            scheduler accepts mask this cycle
//  sel        out  2*SEL_IN     {right_idx,left_idx}, same packing as reduction_mux sel
//  lane_vld   out  2            {right_vld,left_vld}; lane carries a real nonzero
//  last       out  1            final beat of current group
//  out_valid  out  1            sel/lane_vld/last valid
//  out_ready  in   1            downstream consumes beat
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE, rem=0, sel=0, lane_vld=0, last=0, out_valid=0; mask_ready=1 after.
//  States: IDLE (no beat pending) -> ISSUE (beat held in output regs). Handshake = valid&ready.
//  Accept: mask_ready = (state==IDLE) | (out_valid & last & out_ready). On mask accept in cycle N the
//   first beat is registered, out_valid=1 in cycle N+1 (latency 1). Back-to-back groups: no bubble.
//  Beat formation from working mask m: left=ffs(m), right=ffs(m & ~(1<<left)); lane_vld bits = found
//   flags; unfound lane index driven 0. rem <= m with both picked bits cleared.
//  last=1 when rem after this beat is 0. Advance (next beat from rem) only on out_valid&out_ready.
//  Stall: while out_valid & !out_ready, sel/lane_vld/last and rem are held stable (no glitching).
//  ISSUE -> IDLE when last beat consumed and no new mask accepted same cycle; -> ISSUE (new group)
//   if mask_valid that cycle.
//  mask==0: exactly one beat, lane_vld=2'b00, sel=0, last=1 (accumulator still closes the group).
//  Single set bit: one beat, lane_vld=2'b01, last=1. All bits set: NUM_IN/2 beats, all lane_vld=11.
//  mask is sampled only at accept; changes while not accepted are ignored.
//  rst asserted mid-group: group discarded, outputs return to reset values immediately.
// CONFIGURATION
//  SCHED_PERF_CNT_EN defined: adds out ports grp_cnt[31:0] (groups completed) and beat_cnt[31:0]
//   (beats consumed) and nz_cnt[31:0] (sum of popcount(lane_vld) over consumed beats); wrap at 2^32,
//   cleared by rst. Not defined: ports and counters absent, no other behaviour change.
// STRUCTURE
//  reduction_pkg: state enum localparams (ST_IDLE, ST_ISSUE), lane index localparams LANE_L=0,
//   LANE_R=1, function sel_width(NUM_IN). Shared with reduction_mux instantiations.
//  Sub-module ffs_enc #(NUM_IN,SEL_IN): combinational find-first-set -> {found, idx}; two instances
//   (second fed masked vector). Rest (FSM, rem reg, output regs, counters) in this module.
// TESTING (NUM_IN=4, SEL_IN=2, out_ready=1 unless stated)
//  1 mask=4'b1011 -> beat1 sel={2'd1,2'd0} lane_vld=11 last=0; beat2 sel={2'd0,2'd3} lane_vld=01 last=1.
//  2 mask=4'b0000 -> single beat sel=0 lane_vld=00 last=1; mask_ready high again same cycle it is consumed.
//  3 mask=4'b1111 then 4'b0100 back-to-back -> beats {1,0}/11, {3,2}/11 last, {0,2}/01 last; no idle cycle.
//  4 mask=4'b0110, out_ready=0 for 3 cycles -> sel={2'd2,2'd1} lane_vld=11 last=1 held stable; mask_ready=0.
//  5 mask=4'b1111, rst pulsed after beat1 -> out_valid=0, sel=0 asynchronously; next mask 4'b1000 gives
//    sel={2'd0,2'd3} lane_vld=01 last=1.
//  6 SCHED_PERF_CNT_EN: tests 1-3 in sequence -> grp_cnt=4, beat_cnt=6, nz_cnt=8.

Source files
------------

// File: rtl/reduction_pkg.sv
// Shared definitions for the reduction mux and its issue scheduler.
package reduction_pkg;

  // Scheduler states: IDLE has no beat pending, ISSUE holds a beat in the output registers.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } sched_state_e;

  // Lane positions inside the {right,left} select / valid buses.
  localparam int unsigned LANE_L = 0;
  localparam int unsigned LANE_R = 1;

  // Select width needed to address num_in mux inputs.
  function automatic int unsigned sel_width(input int unsigned num_in);
    return (num_in < 2) ? 1 : $clog2(num_in);
  endfunction

endpackage

// File: rtl/reduction_mux_sched_ffs_enc.sv
// Combinational find-first-set: reports whether any bit is set and the lowest set index.
module ffs_enc #(
  parameter int unsigned NUM_IN = 4,
  parameter int unsigned SEL_IN = 2
) (
  input  logic [NUM_IN-1:0] vec,
  output logic              found,
  output logic [SEL_IN-1:0] idx
);

  // Scan from the top down so the lowest set bit is the one left standing.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = int'(NUM_IN) - 1; i >= 0; i--) begin
      if (vec[i]) begin
        found = 1'b1;
        idx   = SEL_IN'(i);
      end
    end
  end

endmodule

// File: rtl/reduction_mux_sched.sv
// Issue scheduler for reduction_mux: walks a nonzero bitmask two set bits per beat,
// lowest first, and drives the mux select bus plus lane-valid / end-of-group flags.
// Optional: define SCHED_PERF_CNT_EN to add grp_cnt / beat_cnt / nz_cnt counters.
module reduction_mux_sched
  import reduction_pkg::*;
#(
  parameter int unsigned NUM_IN = 4,
  parameter int unsigned SEL_IN = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_IN-1:0]   mask,
  input  logic                mask_valid,
  output logic                mask_ready,
  output logic [2*SEL_IN-1:0] sel,
  output logic [1:0]          lane_vld,
  output logic                last,
  output logic                out_valid,
  input  logic                out_ready
`ifdef SCHED_PERF_CNT_EN
  ,
  output logic [31:0]         grp_cnt,
  output logic [31:0]         beat_cnt,
  output logic [31:0]         nz_cnt
`endif
);

  sched_state_e        state_q, state_d;
  logic [NUM_IN-1:0]   rem_q;
  logic [SEL_IN-1:0]   sel_l_q, sel_r_q;
  logic [1:0]          vld_q;
  logic                last_q;

  logic                consume, accept, load;
  logic [NUM_IN-1:0]   work_mask, l_oh, r_vec, r_oh, beat_rem;
  logic                l_found, r_found;
  logic [SEL_IN-1:0]   l_idx, r_idx;

  assign out_valid = (state_q == ST_ISSUE);
  assign sel       = {sel_r_q, sel_l_q};
  assign lane_vld  = vld_q;
  assign last      = last_q;

  // Handshake decode and next state; a new group may start the cycle the old one ends.
  always_comb begin
    consume    = out_valid & out_ready;
    mask_ready = (state_q == ST_IDLE) | (consume & last_q);
    accept     = mask_valid & mask_ready;
    load       = accept | (consume & ~last_q);
    state_d    = state_q;
    if (accept) begin
      state_d = ST_ISSUE;
    end else if (consume && last_q) begin
      state_d = ST_IDLE;
    end
  end

  // Beat source: a freshly accepted mask, otherwise what is left of the current group.
  assign work_mask = accept ? mask : rem_q;

  ffs_enc #(
    .NUM_IN (NUM_IN),
    .SEL_IN (SEL_IN)
  ) u_ffs_left (
    .vec   (work_mask),
    .found (l_found),
    .idx   (l_idx)
  );

  assign l_oh  = l_found ? (NUM_IN'(1) << l_idx) : '0;
  assign r_vec = work_mask & ~l_oh;

  ffs_enc #(
    .NUM_IN (NUM_IN),
    .SEL_IN (SEL_IN)
  ) u_ffs_right (
    .vec   (r_vec),
    .found (r_found),
    .idx   (r_idx)
  );

  assign r_oh     = r_found ? (NUM_IN'(1) << r_idx) : '0;
  assign beat_rem = r_vec & ~r_oh;

  // State, remainder and output beat registers; everything holds while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      sel_l_q <= '0;
      sel_r_q <= '0;
      vld_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        sel_l_q        <= l_idx;
        sel_r_q        <= r_idx;
        vld_q[LANE_L]  <= l_found;
        vld_q[LANE_R]  <= r_found;
        last_q         <= (beat_rem == '0);
        rem_q          <= beat_rem;
      end
    end
  end

`ifdef SCHED_PERF_CNT_EN
  logic [31:0] grp_cnt_q, beat_cnt_q, nz_cnt_q;

  assign grp_cnt  = grp_cnt_q;
  assign beat_cnt = beat_cnt_q;
  assign nz_cnt   = nz_cnt_q;

  // Performance counters advance on consumed beats and wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grp_cnt_q  <= '0;
      beat_cnt_q <= '0;
      nz_cnt_q   <= '0;
    end else if (consume) begin
      beat_cnt_q <= beat_cnt_q + 32'd1;
      nz_cnt_q   <= nz_cnt_q + 32'(vld_q[LANE_L]) + 32'(vld_q[LANE_R]);
      if (last_q) begin
        grp_cnt_q <= grp_cnt_q + 32'd1;
      end
    end
  end
`endif

endmodule
